// File: rtl/mult_controller_if.sv
// Purpose: control/status bundle between mult_controller, its user and the shift-add datapath.
// Latency: n/a (wires only).
// Backpressure: none; start is a level request accepted only while the controller is idle.
//
// Signals:
//   start, abort        user -> controller request / synchronous cancel
//   zero, lsb_b         datapath -> controller status flags (b == 0, b[0])
//   en_*, ld_*          controller -> datapath register enables and mux selects
//   busy, done, err     controller -> user status (done/err are one-cycle pulses)
// Modports: master = controller side, slave = user + datapath side.
interface mult_controller_if;
    logic start;
    logic abort;
    logic zero;
    logic lsb_b;
    logic en_a;
    logic ld_shift_a;
    logic en_b;
    logic ld_shift_b;
    logic en_p;
    logic ld_add_p;
    logic busy;
    logic done;
    logic err;

    modport master (
        input  start, abort, zero, lsb_b,
        output en_a, ld_shift_a, en_b, ld_shift_b, en_p, ld_add_p, busy, done, err
    );

    modport slave (
        output start, abort, zero, lsb_b,
        input  en_a, ld_shift_a, en_b, ld_shift_b, en_p, ld_add_p, busy, done, err
    );
endinterface

// File: rtl/mult_controller.sv
// Purpose: Moore FSM sequencing a shift-add multiplier datapath (load, test/add/shift, done).
// Latency: 3 + 2n + k cycles from start-sampling edge to done (n = MSB index of b + 1, k = popcount(b)).
// Backpressure: start is ignored while busy (not queued); abort cancels any state but IDLE/DONE.
//
// Ports: clk, clr_n (async active-low reset), ctl (mult_controller_if.master).
// Optional build macro MULT_CTRL_WATCHDOG_EN: counts SHIFT visits and forces DONE with err
// when an operation runs WIDTH shifts without the datapath reporting zero.
module mult_controller #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    mult_controller_if.master ctl
);

`ifdef MULT_CTRL_WATCHDOG_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_TEST, S_ADD, S_SHIFT, S_DONE, S_FAULT
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_TEST, S_ADD, S_SHIFT, S_DONE
    } state_t;
`endif

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef MULT_CTRL_WATCHDOG_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] shift_cnt;
    logic             wd_trip;

    // Counts shifts of the current operation; a healthy b empties within WIDTH shifts,
    // so reaching WIDTH with zero still low means the datapath or its flags are broken.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            shift_cnt <= '0;
        end else if (state_q == S_IDLE || state_q == S_LOAD) begin
            shift_cnt <= '0;
        end else if (state_q == S_SHIFT) begin
            shift_cnt <= shift_cnt + 1'b1;
        end
    end

    assign wd_trip = (shift_cnt == CNT_W'(WIDTH));
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (ctl.start) state_d = S_LOAD;
            S_LOAD:  state_d = S_TEST;
            S_TEST: begin
                if (ctl.zero) begin
                    state_d = S_DONE;
`ifdef MULT_CTRL_WATCHDOG_EN
                end else if (wd_trip) begin
                    state_d = S_FAULT;
`endif
                end else if (ctl.lsb_b) begin
                    state_d = S_ADD;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_ADD:   state_d = S_SHIFT;
            S_SHIFT: state_d = S_TEST;
            S_DONE:  state_d = S_IDLE;
`ifdef MULT_CTRL_WATCHDOG_EN
            S_FAULT: state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase

        // Abort cancels mid-operation work only; once done is showing it must complete.
        if (ctl.abort && state_q != S_IDLE && state_q != S_DONE
`ifdef MULT_CTRL_WATCHDOG_EN
            && state_q != S_FAULT
`endif
        ) begin
            state_d = S_IDLE;
        end
    end

    // Moore output decode: depends on state_q only
    always_comb begin
        ctl.en_a       = 1'b0;
        ctl.ld_shift_a = 1'b0;
        ctl.en_b       = 1'b0;
        ctl.ld_shift_b = 1'b0;
        ctl.en_p       = 1'b0;
        ctl.ld_add_p   = 1'b0;
        ctl.busy       = (state_q != S_IDLE);
        ctl.done       = 1'b0;
        ctl.err        = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                ctl.en_a = 1'b1;
                ctl.en_b = 1'b1;
                ctl.en_p = 1'b1;
            end
            S_ADD: begin
                ctl.en_p     = 1'b1;
                ctl.ld_add_p = 1'b1;
            end
            S_SHIFT: begin
                ctl.en_a       = 1'b1;
                ctl.ld_shift_a = 1'b1;
                ctl.en_b       = 1'b1;
                ctl.ld_shift_b = 1'b1;
            end
            S_DONE: ctl.done = 1'b1;
`ifdef MULT_CTRL_WATCHDOG_EN
            S_FAULT: begin
                ctl.done = 1'b1;
                ctl.err  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: doc/mult_controller.md
# mult_controller

Control unit for the sequential shift-add multiplier, directly driving the multiplier datapath's register enables and MUX selects. It consumes the datapath's `zero` and `lsb_b` status flags. It runs one multiplication per `start` request: load, then test/add/shift iterations until the multiplier register empties, then a one-cycle `done` pulse. A user-level `start`/`busy`/`done` handshake is exposed upstream.

## Interface
- `WIDTH`, 4, multiplier operand width; bounds the watchdog iteration limit.
- `clk`  in  1  system clock, rising-edge.
- `clr_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a multiplication; sampled only in IDLE.
- `abort`  in  1  synchronous cancel; returns to IDLE without `done`.
- `zero`  in  1  datapath flag, b register == 0.
- `lsb_b`  in  1  datapath flag, b register bit 0.
- `en_a`, `ld_shift_a`  out  1 each  a register enable / select (0 = load `a_in` zero-extended, 1 = a << 1).
- `en_b`, `ld_shift_b`  out  1 each  b register enable / select (0 = load `b_in`, 1 = b >> 1).
- `en_p`, `ld_add_p`  out  1 each  p register enable / select (0 = clear to 0, 1 = p + a).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; product valid on datapath `p_out` in the same cycle.
- `err`  out  1  watchdog fault, valid with `done`; see Configuration.

## Operation
- Moore FSM. All outputs decode from the state register only, with no combinational input-to-output path.
- Decoded output names that are not asserted are 0 in that state.
- IDLE: all outputs 0.
  - `start`=1 -> LOAD.
- LOAD: `en_a`=`en_b`=`en_p`=1 with all selects 0. This loads a, loads b and clears p. -> TEST.
- TEST: no enables.
  - `zero`=1 -> DONE.
  - else `lsb_b`=1 -> ADD.
  - else -> SHIFT.
- ADD: `en_p`=1, `ld_add_p`=1. -> SHIFT.
- SHIFT: `en_a`=`ld_shift_a`=1 and `en_b`=`ld_shift_b`=1. -> TEST.
- DONE: `done`=1. -> IDLE unconditionally.
- `abort`=1 in any non-IDLE state except DONE -> IDLE next edge. p contents are then undefined.
- `abort` in DONE is ignored, so `done` still pulses.
- `start` while `busy` is ignored and not queued. `start` held high through DONE starts a new operation from IDLE on the following edge.
- Simultaneous `start`+`abort` in IDLE: start wins, because abort has no effect in IDLE.

## Timing
- Reset: state=IDLE. All outputs 0, including `busy`, `done` and `err`. The watchdog counter is 0. Reset is asynchronous: assertion mid-operation drives the outputs to 0 immediately, not at the next edge.
- `a_in`/`b_in` must be stable during the LOAD cycle; they are captured by the datapath at the end of LOAD.
- Let n = index of the most significant set bit of b, plus 1 (n = 0 for b = 0), and k = popcount(b).
- Cycles from the `start`-sampling edge to `done` high, inclusive of DONE: 3 + 2n + k.
  - b=0: 3.
  - b=3: 9.
  - b=8: 12.
  - b=15: 15.
- `busy` rises the cycle after `start` is sampled and falls the cycle after DONE.
- `done` is high for exactly one cycle; `err` is only ever high in that same cycle.
- Back-to-back operations: minimum start-to-start spacing is (3 + 2n + k) + 1 cycles.

## Configuration
- `MULT_CTRL_WATCHDOG_EN` defined:
  - Adds a $clog2(WIDTH+1)-bit counter of SHIFT visits. It clears in LOAD and in IDLE.
  - Entering TEST with count == WIDTH and `zero`=0 forces -> DONE with `err`=1. This guards against datapath or flag faults.
  - Normal operands never trigger it.
- Macro not defined:
  - No counter is built, and `err` is tied to 0.
  - A stuck `zero`=0 flag loops TEST/SHIFT indefinitely; `abort` is the only exit.

## Test plan
- Controller paired with the datapath, `a_in`=2, `b_in`=3, pulse `start` -> `done` 9 cycles later, `p_out`=6, `err`=0, `busy` low the following cycle.
- `a_in`=15, `b_in`=15 -> `done` after 15 cycles, `p_out`=225; `a_in`=9, `b_in`=0 -> `done` after 3 cycles, `p_out`=0.
- Pulse `start` again during SHIFT of a running 5×7 -> ignored, single `done`, `p_out`=35; `start` held high through DONE -> second operation begins from IDLE.
- Drive `clr_n`=0 mid-ADD (asynchronous, between edges) -> all outputs 0 immediately. Release, then `start` with 3×4 -> `p_out`=12, latency 10.
- `abort` in TEST of a 6×13 -> IDLE next edge, no `done`. `abort` during DONE -> `done` still pulses.
- With `MULT_CTRL_WATCHDOG_EN`, stub `zero`=0 and `lsb_b`=0 -> `done`=1 with `err`=1, 11 cycles after `start`. Without the macro, the same stimulus never raises `done` within 100 cycles, and `err` stays 0.
